hier_leaf_fifo: RTL

- Leaf-level buffering stage instantiated beneath the hierarchical root modules. Absorbs a valid/ready data stream from the upstream producer and presents it to the downstream consumer in order.
- Synchronous single-clock FIFO with occupancy reporting, almost-full warning and sticky overflow/underflow error flags.
- First concrete sequential leaf in the hierarchy tree; sibling instances are expected side by side under one parent.

---
 rtl/hier_leaf_pkg.sv | 12 +
 rtl/hier_leaf_fifo_mem.sv | 28 ++
 rtl/hier_leaf_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hier_leaf_pkg.sv
// Shared defaults and pointer helper for the hierarchical leaf FIFO.
// Depths need not be powers of two, so pointer wrap is an explicit compare.
package hier_leaf_pkg;

    localparam int HIER_LEAF_DATA_W_DEFAULT = 8;
    localparam int HIER_LEAF_DEPTH_DEFAULT  = 4;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/hier_leaf_fifo_mem.sv
// DEPTH x DATA_W storage for the leaf FIFO: one synchronous write port,
// one asynchronous read port, contents deliberately left unreset.
module hier_leaf_fifo_mem
    import hier_leaf_pkg::*;
#(
    parameter int DATA_W = HIER_LEAF_DATA_W_DEFAULT,
    parameter int DEPTH  = HIER_LEAF_DEPTH_DEFAULT,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hier_leaf_fifo.sv
// Single-clock valid/ready leaf FIFO with occupancy, almost-full and sticky error flags.
// Define HIER_LEAF_FIFO_STRICT_EN for the underflow flag and handshake assertions.
module hier_leaf_fifo
    import hier_leaf_pkg::*;
#(
    parameter int DATA_W    = HIER_LEAF_DATA_W_DEFAULT,
    parameter int DEPTH     = HIER_LEAF_DEPTH_DEFAULT,
    parameter int AF_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_overflow_q, err_overflow_d;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head_data;

    // Handshake depends only on registered occupancy, never on out_ready.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        err_overflow_d = err_overflow_q | (in_valid & full);
        if (push) begin
            wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    hier_leaf_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (head_data)
    );

    // Storage is unreset, so mask the head word to zero whenever nothing is held.
    assign out_data     = empty ? '0 : head_data;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign err_overflow = err_overflow_q;

`ifdef HIER_LEAF_FIFO_STRICT_EN
    logic err_underflow_q, err_underflow_d;

    always_comb begin
        err_underflow_d = err_underflow_q | (out_ready & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow_q <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_underflow = err_underflow_q;

`ifndef SYNTHESIS
    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> in_valid);
    a_data_held: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> $stable(in_data));
`endif
`else
    assign err_underflow = 1'b0;
`endif

endmodule
